// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding,
// fetch FSM state encodings, reset PC default and the IF/ID payload.
package fetch_stage_pkg;
    localparam logic [31:0] NOP_INST           = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ifid_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {inst, pc} holding register. Catches a fetch response that
// arrives while IF/ID is occupied and not being consumed.
// Clear wins over load; load wins over unload (load+unload keeps it full).
module fetch_skid_buffer
    import fetch_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_clear,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_full,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc
);
    logic  full_q, full_d;
    ifid_t data_q, data_d;

    // Next-state for the entry and its full flag
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (i_clear) begin
            full_d = 1'b0;
        end else if (i_load) begin
            full_d      = 1'b1;
            data_d.inst = i_inst;
            data_d.pc   = i_pc;
        end else if (i_unload) begin
            full_d = 1'b0;
        end
    end

    // Entry registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full_q      <= 1'b0;
            data_q.inst <= NOP_INST;
            data_q.pc   <= 32'h0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign o_full = full_q;
    assign o_inst = data_q.inst;
    assign o_pc   = data_q.pc;
endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps one read outstanding
// to instruction memory and drives the IF/ID register for decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned PC in FETCH
// raises o_trap and halts instead of issuing a request).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_flush_target,
    input  logic        i_halt,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid,
    output logic        o_trap
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic         valid_q, valid_d;
    ifid_t        ifid_q, ifid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic         trap_q, trap_d;
`endif

    logic        consume, ifid_free, halt_take, can_issue, req, accept, misalign;
    logic [31:0] flush_tgt;
    logic        skid_full, skid_load, skid_unload, skid_clear;
    logic [31:0] skid_inst, skid_pc;

    fetch_skid_buffer u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (skid_load),
        .i_unload(skid_unload),
        .i_clear (skid_clear),
        .i_inst  (i_imem_rdata),
        .i_pc    (pc_q),
        .o_full  (skid_full),
        .o_inst  (skid_inst),
        .o_pc    (skid_pc)
    );

    // Handshake decode; a discarded response still in flight (drop_q) holds off new requests
    always_comb begin
        consume   = valid_q & ~i_stall;
        ifid_free = ~valid_q | consume;
        halt_take = i_halt & consume;
        can_issue = ifid_free | ~skid_full;
`ifdef FETCH_MISALIGN_TRAP_EN
        flush_tgt = i_flush_target;
        misalign  = (pc_q[1:0] != 2'b00);
`else
        flush_tgt = i_flush_target & 32'hFFFF_FFFC;
        misalign  = 1'b0;
`endif
        req    = (state_q == ST_FETCH) & can_issue & ~drop_q & ~misalign;
        accept = req & i_imem_ready;
    end

    // Fetch FSM next-state, IF/ID and skid control; flush beats halt beats normal flow
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        valid_d     = valid_q;
        ifid_d      = ifid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d      = trap_q;
`endif
        if (i_flush) begin
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            pc_d       = flush_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_d     = 1'b0;
`endif
            case (state_q)
                ST_WAIT: begin
                    if (i_imem_valid) begin
                        state_d = ST_FETCH;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (accept) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end else if (halt_take) begin
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            state_d    = ST_HALTED;
            if (((state_q == ST_WAIT) & ~i_imem_valid) | accept)
                drop_d = 1'b1;
            else if (state_q == ST_WAIT)
                drop_d = 1'b0;
        end else begin
            if (consume) begin
                if (skid_full) begin
                    ifid_d.inst = skid_inst;
                    ifid_d.pc   = skid_pc;
                    valid_d     = 1'b1;
                    skid_unload = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            case (state_q)
                ST_FETCH: begin
                    if (misalign & ifid_free & ~skid_full) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        trap_d = 1'b1;
`endif
                        valid_d     = 1'b1;
                        ifid_d.inst = NOP_INST;
                        ifid_d.pc   = pc_q;
                        state_d     = ST_HALTED;
                    end else if (accept) begin
                        state_d = ST_WAIT;
                    end else if (drop_q & i_imem_valid) begin
                        drop_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (i_imem_valid) begin
                        state_d = ST_FETCH;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            pc_d = pc_q + 32'd4;
                            if (ifid_free & ~skid_full) begin
                                ifid_d.inst = i_imem_rdata;
                                ifid_d.pc   = pc_q;
                                valid_d     = 1'b1;
                            end else begin
                                skid_load = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (drop_q & i_imem_valid) drop_d = 1'b0;
                end
            endcase
        end
    end

    // State, PC and IF/ID registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_ADDR;
            drop_q      <= 1'b0;
            valid_q     <= 1'b0;
            ifid_q.inst <= NOP_INST;
            ifid_q.pc   <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            ifid_q  <= ifid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    assign o_imem_req  = req;
    assign o_imem_addr = pc_q;
    assign o_inst      = ifid_q.inst;
    assign o_pc        = ifid_q.pc;
    assign o_pc_plus4  = ifid_q.pc + 32'd4;
    assign o_valid     = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign o_trap      = trap_q;
`else
    assign o_trap      = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model answers accepted
// requests after a programmable latency (data = 0xA000_0000 | addr), the
// main process pushes hand-computed {pc, inst} and a monitor pops one
// entry each time decode would consume IF/ID.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_imem_req, o_valid, o_trap;
    logic [31:0] o_imem_addr, o_inst, o_pc, o_pc_plus4;
    logic        i_imem_ready, i_imem_valid;
    logic [31:0] i_imem_rdata;
    logic        i_stall, i_flush, i_halt;
    logic [31:0] i_flush_target;

    fetch_stage dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ready(i_imem_ready), .i_imem_valid(i_imem_valid), .i_imem_rdata(i_imem_rdata),
        .i_stall(i_stall), .i_flush(i_flush), .i_flush_target(i_flush_target), .i_halt(i_halt),
        .o_inst(o_inst), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_valid(o_valid), .o_trap(o_trap)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc = pc; e.inst = inst;
        sb.push_back(e);
    endtask

    // Instruction memory model: budget limits how many requests get accepted
    int          budget = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    int          mem_cnt = 0;
    bit          mem_pend = 0;
    logic [31:0] mem_addr = 0;
    logic [31:0] last_addr = 0;

    initial begin
        i_imem_valid = 0; i_imem_ready = 0; i_imem_rdata = 0;
        forever begin
            @(negedge clk);
            i_imem_valid = 0;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    i_imem_valid = 1;
                    i_imem_rdata = 32'hA000_0000 | mem_addr;
                    mem_pend = 0;
                end
            end
            #1 i_imem_ready = (budget > 0);
            #1 if (o_imem_req && i_imem_ready && !rst) begin
                mem_pend = 1; mem_addr = o_imem_addr; mem_cnt = lat;
                budget--; acc_cnt++; last_addr = o_imem_addr;
            end
        end
    end

    // Monitor: every consumed IF/ID entry must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && o_valid && !i_stall) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_consume: got pc %h inst %h, none expected", o_pc, o_inst);
                end else begin
                    mon_e = sb.pop_front();
                    check("ifid_pc", o_pc, mon_e.pc);
                    check("ifid_inst", o_inst, mon_e.inst);
                    check("ifid_pc_plus4", o_pc_plus4, mon_e.pc + 32'd4);
                end
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check(name, sb.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_acc(input int target, input string name);
        int k;
        k = 0;
        while (acc_cnt < target && k < 60) begin
            @(negedge clk); #3; k++;
        end
        if (acc_cnt < target) check(name, acc_cnt, target);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (!o_valid && k < 60);
        if (!o_valid) check(name, o_valid, 1);
    endtask

    logic [7:0]  vpat;
    logic [31:0] hold_pc, hold_inst;
    bit          flag;
    int          base;

    initial begin
        i_stall = 0; i_flush = 0; i_flush_target = 0; i_halt = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_inst", o_inst, 32'h0000_0013);
        check("rst_pc", o_pc, 0);
        check("rst_trap", o_trap, 0);
        check("rst_addr", o_imem_addr, 0);
        #1 rst = 0;

        // Streaming: o_valid every other cycle
        @(negedge clk);
        budget = 3;
        push(32'h0, 32'hA000_0000); push(32'h4, 32'hA000_0004); push(32'h8, 32'hA000_0008);
        for (int i = 0; i < 8; i++) begin
            #4 vpat[i] = o_valid;
            @(negedge clk);
        end
        check("t1_valid_pattern", vpat, 8'h54);
        drain("t1_drain");

        // Stall while streaming: IF/ID frozen, one request fills the skid
        @(negedge clk);
        budget = 5;
        push(32'h0C, 32'hA000_000C); push(32'h10, 32'hA000_0010); push(32'h14, 32'hA000_0014);
        push(32'h18, 32'hA000_0018); push(32'h1C, 32'hA000_001C);
        wait_valid("t2_first_valid");
        i_stall = 1;
        base = acc_cnt; hold_pc = o_pc; hold_inst = o_inst; flag = 1;
        repeat (6) begin
            @(negedge clk);
            #4 if (o_pc !== hold_pc || o_inst !== hold_inst || o_valid !== 1'b1) flag = 0;
        end
        check("t2_frozen", flag, 1);
        check("t2_reqs_during_stall", acc_cnt - base, 1);
        check("t2_req_blocked", o_imem_req, 0);
        @(negedge clk);
        i_stall = 0;
        drain("t2_drain");

        // Flush in WAIT, stale response 3 cycles later is dropped
        @(negedge clk);
        lat = 3; budget = 2; base = acc_cnt;
        push(32'h100, 32'hA000_0100);
        wait_acc(base + 1, "t3_first_accept");
        @(negedge clk);
        i_flush = 1; i_flush_target = 32'h100;
        @(negedge clk);
        i_flush = 0;
        #3 check("t3_valid_after_flush", o_valid, 0);
        wait_acc(base + 2, "t3_refetch_accept");
        check("t3_refetch_addr", last_addr, 32'h100);
        drain("t3_drain");
        lat = 1;

        // Flush together with a response while stalled
        @(negedge clk);
        budget = 2;
        wait_valid("t4_valid");
        i_stall = 1;
        @(negedge clk);
        i_flush = 1; i_flush_target = 32'h100;
        @(negedge clk);
        i_flush = 0;
        #3;
        check("t4_valid_after_flush", o_valid, 0);
        check("t4_next_addr", o_imem_addr, 32'h100);
        check("t4_req", o_imem_req, 1);
        @(negedge clk);
        i_stall = 0; budget = 1;
        push(32'h100, 32'hA000_0100);
        drain("t4_drain");

        // Halt, then resume via flush to 0x40
        @(negedge clk);
        budget = 1;
        push(32'h104, 32'hA000_0104);
        wait_valid("t5_valid");
        i_halt = 1;
        @(negedge clk);
        i_halt = 0; budget = 1;
        #3 check("t5_valid_after_halt", o_valid, 0);
        base = acc_cnt; flag = 1;
        repeat (20) begin
            @(negedge clk);
            #4 if (o_imem_req !== 1'b0) flag = 0;
        end
        check("t5_req_quiet", flag, 1);
        check("t5_no_accepts", acc_cnt - base, 0);
        @(negedge clk);
        i_flush = 1; i_flush_target = 32'h40;
        push(32'h40, 32'hA000_0040);
        @(negedge clk);
        i_flush = 0;
        wait_acc(base + 1, "t5_resume_accept");
        check("t5_resume_addr", last_addr, 32'h40);
        drain("t5_drain");

        // Async reset while WAIT, stale response afterwards ignored
        @(negedge clk);
        lat = 3; budget = 1; base = acc_cnt;
        wait_acc(base + 1, "t6_accept");
        @(negedge clk);
        #1 rst = 1;
        #1;
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_inst", o_inst, 32'h0000_0013);
        check("t6_rst_pc", o_pc, 0);
        check("t6_rst_addr", o_imem_addr, 0);
        check("t6_rst_req", o_imem_req, 1);
        @(negedge clk);
        #1 rst = 0;
        repeat (3) @(negedge clk);
        #3 check("t6_stale_ignored", o_valid, 0);
        @(negedge clk);
        lat = 1; budget = 1; base = acc_cnt;
        push(32'h0, 32'hA000_0000);
        wait_acc(base + 1, "t6_post_accept");
        check("t6_post_addr", last_addr, 32'h0);
        drain("t6_drain");

        // Misaligned redirect target
        @(negedge clk);
        base = acc_cnt;
        i_flush = 1; i_flush_target = 32'h102;
`ifdef FETCH_MISALIGN_TRAP_EN
        push(32'h102, 32'h0000_0013);
        @(negedge clk);
        i_flush = 0; budget = 1;
        @(negedge clk);
        #3 check("t7_trap", o_trap, 1);
        repeat (5) @(negedge clk);
        check("t7_no_request", acc_cnt - base, 0);
        budget = 0;
        drain("t7_drain");
`else
        push(32'h100, 32'hA000_0100);
        @(negedge clk);
        i_flush = 0; budget = 1;
        wait_acc(base + 1, "t7_accept");
        check("t7_aligned_addr", last_addr, 32'h100);
        check("t7_trap_zero", o_trap, 0);
        drain("t7_drain");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined RV32I hart. It owns the PC, issues one-outstanding-request reads to instruction memory, and drives the IF/ID register consumed by decode (instruction, PC, valid). It honours decode's load-use stall and halt, and applies execute's flush/redirect for the always-not-taken predictor.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
o_imem_req  out  1  read request valid
o_imem_addr  out  32  read address (current PC)
i_imem_ready  in  1  memory accepts request this cycle
i_imem_valid  in  1  read data valid (≥1 cycle after accept)
i_imem_rdata  in  32  instruction word
i_stall  in  1  decode load-use stall; hold IF/ID
i_flush  in  1  execute redirect (branch taken / jump)
i_flush_target  in  32  redirect PC
i_halt  in  1  decode sees halt in IF/ID
o_inst  out  32  IF/ID instruction
o_pc  out  32  PC of o_inst
o_pc_plus4  out  32  o_pc + 4
o_valid  out  1  IF/ID holds a live instruction
o_trap  out  1  misaligned fetch target (0 unless macro enabled)

Behaviour:
- Reset (async): pc=RESET_ADDR, state=FETCH, o_valid=0, o_inst=32'h0000_0013 (NOP), o_pc=0, drop=0, skid empty, o_trap=0.
- Consume: IF/ID is taken by decode when o_valid & ~i_stall.
- FETCH: o_imem_req=1, o_imem_addr=pc. Request is issued only if IF/ID will be free (empty or being consumed) or the skid entry is empty. Accept (i_imem_ready) -> WAIT.
- WAIT: o_imem_req=0. On i_imem_valid: drop=1 -> discard, clear drop, -> FETCH. Otherwise: if IF/ID free, load o_inst/o_pc/o_valid=1; else write the skid entry. pc<=pc+4, -> FETCH.
- Skid: when IF/ID is consumed and the skid entry is full, the skid entry moves into IF/ID the same cycle.
- Throughput: one instruction per 2 cycles minimum; no back-to-back requests.
- Flush (highest priority): o_valid<=0, skid cleared, pc<=i_flush_target, leaves HALTED. In WAIT without same-cycle response: stay WAIT, drop<=1. In WAIT with same-cycle response: response discarded, -> FETCH. In FETCH: a request accepted that cycle sets drop<=1.
- Stall: IF/ID, o_pc, and o_inst are frozen. The fetch FSM continues until the skid entry fills.
- Halt: when i_halt & o_valid & ~i_stall, the halt is consumed. Then o_valid<=0, skid cleared, state->HALTED (any outstanding response is discarded via drop). HALTED: o_imem_req=0 until reset or flush.
- Memory response arriving in FETCH/HALTED without a request outstanding: ignored.
- Widths: pc arithmetic is modulo 2^32; pc+4 wraps at 32'hFFFF_FFFC -> 0.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: if pc[1:0]!=0 in FETCH, no request is issued. o_trap<=1, o_valid<=1 with o_inst=NOP and o_pc=pc, then the FSM enters HALTED. o_trap clears on flush or reset.
- Undefined: i_flush_target[1:0] is forced to 0, and o_trap is tied to 0.

Decomposition:
Shared package holds:
- NOP encoding 32'h0000_0013
- state encodings FETCH/WAIT/HALTED
- RESET_ADDR default
- IF/ID payload struct {inst, pc}

Sub-module fetch_skid_buffer: one-entry {inst, pc} holding register with full flag, load/unload/clear.

Test Plan:
- Reset, ready=1, valid 1 cycle after accept -> o_pc sequence 0x0,0x4,0x8 with o_valid pulses every 2 cycles; o_inst matches rdata.
- Stall held 6 cycles while streaming -> o_inst/o_pc frozen, skid fills, exactly one further request issued, none lost or duplicated after release.
- Flush to 0x100 while in WAIT, response arrives 3 cycles later -> response discarded, next request addr 0x100, o_valid=0 until 0x100 data returns.
- Flush same cycle as response and stall -> o_valid=0 next cycle, skid empty, next o_imem_addr=0x100.
- Halt in IF/ID, unstalled -> o_valid=0 next cycle, o_imem_req stays 0 for 20 cycles; subsequent flush to 0x40 resumes fetch at 0x40.
- Async reset asserted mid-WAIT -> all outputs at reset values immediately; post-reset first address RESET_ADDR, stale response ignored. With FETCH_MISALIGN_TRAP_EN, flush to 0x102 -> o_trap=1, no request issued.
